mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-requester arbiter (processor and DMA/loader) sharing one synchronous
//   single-port memory. A three-state FSM (IDLE, OWN_CPU, OWN_DMA) owns the
//   memory bus. Arbitration from IDLE costs one cycle. An owner is forced off
//   after MAX_BURST consecutive transfers only if the other side is waiting.
//   Read data comes back one cycle after the read transfer.
//
// Parameters
//   WIDTH      data/address width of every data and address port
//   MAX_BURST  transfers per grant while the other requester waits (1..15)
//
// Configuration macro
//   MEM_ARB_RR_EN  when defined, a tie in IDLE goes to the requester that was
//                  not the most recent owner. When undefined, the processor
//                  always wins a tie.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   cpu_req/we/adr/wdata         processor request
//   cpu_gnt                      processor owns memory this cycle
//   cpu_rvalid, cpu_rdata        processor read return (cycle after read)
//   dma_*                        same set for the DMA/loader requester
//   mem_en/we/adr/wdata          memory command (all zero when idle)
//   mem_rdata                    memory read data, one cycle after address
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_rvalid,
    output logic [WIDTH-1:0] cpu_rdata,

    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [WIDTH-1:0] dma_adr,
    input  logic [WIDTH-1:0] dma_wdata,
    output logic             dma_gnt,
    output logic             dma_rvalid,
    output logic [WIDTH-1:0] dma_rdata,

    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DMA = 2'd2
    } state_t;

    // Counter value at which a waiting requester takes over.
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t     state;
    logic [3:0] burst_cnt;
    logic       cpu_rv_q;
    logic       dma_rv_q;

    logic       cpu_xfer;
    logic       dma_xfer;
    logic       at_last;
    logic       tie_cpu;
    logic       to_cpu;
    logic       to_dma;
    logic       to_idle;

    // A transfer is ownership plus a live request from the owner.
    assign cpu_xfer = (state == OWN_CPU) && cpu_req;
    assign dma_xfer = (state == OWN_DMA) && dma_req;
    assign at_last  = (burst_cnt == BURST_LAST);

    assign cpu_gnt  = cpu_xfer;
    assign dma_gnt  = dma_xfer;

`ifdef MEM_ARB_RR_EN
    // 1 = processor was the most recent owner. Clears to 0 so that the
    // processor wins the first tie after reset.
    logic last_cpu;
    assign tie_cpu = !last_cpu;
`else
    assign tie_cpu = 1'b1;
`endif

    // Next-ownership decode. At most one of to_cpu/to_dma/to_idle is set;
    // none set means the current owner keeps the bus.
    always_comb begin
        to_cpu  = 1'b0;
        to_dma  = 1'b0;
        to_idle = 1'b0;
        case (state)
            IDLE: begin
                to_cpu = cpu_req && (!dma_req || tie_cpu);
                to_dma = dma_req && !to_cpu;
            end
            OWN_CPU: begin
                // Hand over when the owner has stopped, or when it has used
                // its burst and the other side is waiting.
                to_dma  = dma_req && (!cpu_req || at_last);
                to_idle = !cpu_req && !dma_req;
            end
            OWN_DMA: begin
                to_cpu  = cpu_req && (!dma_req || at_last);
                to_idle = !dma_req && !cpu_req;
            end
            default: to_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            cpu_rv_q  <= 1'b0;
            dma_rv_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_cpu  <= 1'b0;
`endif
        end else begin
            cpu_rv_q <= cpu_xfer && !cpu_we;
            dma_rv_q <= dma_xfer && !dma_we;

            if (to_cpu) begin
                state     <= OWN_CPU;
                burst_cnt <= '0;
            end else if (to_dma) begin
                state     <= OWN_DMA;
                burst_cnt <= '0;
            end else if (to_idle) begin
                state     <= IDLE;
                burst_cnt <= '0;
            end else if ((cpu_xfer || dma_xfer) && !at_last) begin
                // Saturates at BURST_LAST so a lone owner can run forever.
                burst_cnt <= burst_cnt + 4'd1;
            end

`ifdef MEM_ARB_RR_EN
            if (to_cpu)
                last_cpu <= 1'b1;
            else if (to_dma)
                last_cpu <= 1'b0;
`endif
        end
    end

    // Memory command mux: owner's fields during a transfer, zero otherwise.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        if (cpu_xfer) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_adr   = cpu_adr;
            mem_wdata = cpu_wdata;
        end else if (dma_xfer) begin
            mem_en    = 1'b1;
            mem_we    = dma_we;
            mem_adr   = dma_adr;
            mem_wdata = dma_wdata;
        end
    end

    // Read return. Gating with reset drops a read whose return cycle
    // coincides with a reset, so it is never seen by the requester.
    assign cpu_rvalid = cpu_rv_q && !reset;
    assign dma_rvalid = dma_rv_q && !reset;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req, cpu_we, dma_req, dma_we;
    logic [W-1:0] cpu_adr, cpu_wdata, dma_adr, dma_wdata;
    logic         cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [W-1:0] cpu_rdata, dma_rdata;
    logic         mem_en, mem_we;
    logic [W-1:0] mem_adr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous-read memory: contents mem[i] = i ^ 0x5A, except 0x05 = 0xA3.
    logic [W-1:0] mem [256];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= W'(i ^ 8'h5A);
            mem[5] <= 8'hA3;
        end else if (mem_en && mem_we) begin
            mem[mem_adr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_adr];
    end

    typedef struct {
        logic         creq, cwe;
        logic [W-1:0] cadr, cwd;
        logic         dreq, dwe;
        logic [W-1:0] dadr, dwd;
        logic         ecg, edg, een, ewe;
        logic [W-1:0] eadr, ewd;
        logic         ecrv;
        logic [W-1:0] ecrd;
        logic         edrv;
        logic [W-1:0] edrd;
    } vec_t;

    function automatic vec_t mk(int creq, int cwe, int cadr, int cwd,
                                int dreq, int dwe, int dadr, int dwd,
                                int ecg, int edg, int een, int ewe, int eadr, int ewd,
                                int ecrv, int ecrd, int edrv, int edrd);
        vec_t v;
        v.creq = 1'(creq); v.cwe = 1'(cwe); v.cadr = W'(cadr); v.cwd = W'(cwd);
        v.dreq = 1'(dreq); v.dwe = 1'(dwe); v.dadr = W'(dadr); v.dwd = W'(dwd);
        v.ecg = 1'(ecg); v.edg = 1'(edg); v.een = 1'(een); v.ewe = 1'(ewe);
        v.eadr = W'(eadr); v.ewd = W'(ewd);
        v.ecrv = 1'(ecrv); v.ecrd = W'(ecrd); v.edrv = 1'(edrv); v.edrd = W'(edrd);
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        cpu_req = v.creq; cpu_we = v.cwe; cpu_adr = v.cadr; cpu_wdata = v.cwd;
        dma_req = v.dreq; dma_we = v.dwe; dma_adr = v.dadr; dma_wdata = v.dwd;
    endtask

    task automatic check_outs(string tag, vec_t v);
        chk({tag, ".cpu_gnt"},    32'(cpu_gnt),    32'(v.ecg));
        chk({tag, ".dma_gnt"},    32'(dma_gnt),    32'(v.edg));
        chk({tag, ".mem_en"},     32'(mem_en),     32'(v.een));
        chk({tag, ".mem_we"},     32'(mem_we),     32'(v.ewe));
        chk({tag, ".mem_adr"},    32'(mem_adr),    32'(v.eadr));
        chk({tag, ".mem_wdata"},  32'(mem_wdata),  32'(v.ewd));
        chk({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'(v.ecrv));
        chk({tag, ".cpu_rdata"},  32'(cpu_rdata),  32'(v.ecrd));
        chk({tag, ".dma_rvalid"}, 32'(dma_rvalid), 32'(v.edrv));
        chk({tag, ".dma_rdata"},  32'(dma_rdata),  32'(v.edrd));
        chk({tag, ".one_hot_gnt"}, 32'(cpu_gnt && dma_gnt), 32'd0);
    endtask

    // Drive at the falling edge, compare shortly after, then let the rising
    // edge advance the design.
    task automatic step(string tag, vec_t v);
        @(negedge clk);
        drive(v);
        #2;
        check_outs(tag, v);
    endtask

    vec_t tbl [29];
    vec_t zero;

    initial begin
        zero = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0);

        // --- reset release, cpu read of 0x05 ---
        tbl[0]  = mk(1,0,8'h05,0, 0,0,0,0, 0,0,0,0,0,0,         0,0,0,0);
        tbl[1]  = mk(1,0,8'h05,0, 0,0,0,0, 1,0,1,0,8'h05,0,     0,0,0,0);
        tbl[2]  = mk(0,0,0,0,     0,0,0,0, 0,0,0,0,0,0,         1,8'hA3,0,0);
        tbl[3]  = zero;
        // --- dma alone writes 0x3C to 0x10 for 6 cycles ---
        tbl[4]  = mk(0,0,0,0, 1,1,8'h10,8'h3C, 0,0,0,0,0,0, 0,0,0,0);
        for (int i = 5; i <= 10; i++)
            tbl[i] = mk(0,0,0,0, 1,1,8'h10,8'h3C, 0,1,1,1,8'h10,8'h3C, 0,0,0,0);
        tbl[11] = zero;
        // --- dma reads the written value back ---
        tbl[12] = mk(0,0,0,0, 1,0,8'h10,0, 0,0,0,0,0,0,     0,0,0,0);
        tbl[13] = mk(0,0,0,0, 1,0,8'h10,0, 0,1,1,0,8'h10,0, 0,0,0,0);
        tbl[14] = mk(0,0,0,0, 0,0,0,0,     0,0,0,0,0,0,     0,0,1,8'h3C);
        // --- tie after dma-owned burst: cpu wins either build; then 4/4 ---
        tbl[15] = mk(1,0,8'h01,0, 1,0,8'h02,0, 0,0,0,0,0,0, 0,0,0,0);
        for (int i = 16; i <= 19; i++)
            tbl[i] = mk(1,0,8'h01,0, 1,0,8'h02,0, 1,0,1,0,8'h01,0,
                        (i == 16) ? 0 : 1, (i == 16) ? 0 : 8'h5B, 0,0);
        for (int i = 20; i <= 23; i++)
            tbl[i] = mk(1,0,8'h01,0, 1,0,8'h02,0, 0,1,1,0,8'h02,0,
                        (i == 20) ? 1 : 0, (i == 20) ? 8'h5B : 0,
                        (i == 20) ? 0 : 1, (i == 20) ? 0 : 8'h58);
        tbl[24] = mk(1,0,8'h01,0, 1,0,8'h02,0, 1,0,1,0,8'h01,0, 0,0,1,8'h58);
        // owner drops mid-burst, other idle: no transfer, IDLE next
        tbl[25] = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 1,8'h5B,0,0);
        // --- tie after cpu-owned burst ---
        tbl[26] = mk(1,0,8'h01,0, 1,0,8'h02,0, 0,0,0,0,0,0, 0,0,0,0);
`ifdef MEM_ARB_RR_EN
        tbl[27] = mk(1,0,8'h01,0, 1,0,8'h02,0, 0,1,1,0,8'h02,0, 0,0,0,0);
        tbl[28] = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,1,8'h58);
`else
        tbl[27] = mk(1,0,8'h01,0, 1,0,8'h02,0, 1,0,1,0,8'h01,0, 0,0,0,0);
        tbl[28] = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 1,8'h5B,0,0);
`endif

        // Reset state
        reset = 1'b1;
        drive(zero);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check_outs("reset", zero);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 29; i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // Reset in the return cycle of a cpu read of 0x07 drops the rvalid.
        step("r41_idle", mk(1,0,8'h07,0, 0,0,0,0, 0,0,0,0,0,0,     0,0,0,0));
        step("r41_xfer", mk(1,0,8'h07,0, 0,0,0,0, 1,0,1,0,8'h07,0, 0,0,0,0));
        @(negedge clk);
        reset = 1'b1;
        drive(zero);
        #2;
        check_outs("r41_rst", zero);
        // Released with cpu requesting: one IDLE cycle before the grant.
        @(negedge clk);
        reset = 1'b0;
        drive(mk(1,0,8'h05,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0));
        #2;
        check_outs("r34_idle", mk(1,0,8'h05,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0));
        step("r34_gnt",  mk(1,0,8'h05,0, 0,0,0,0, 1,0,1,0,8'h05,0, 0,0,0,0));
        step("r34_rv",   mk(0,0,0,0,     0,0,0,0, 0,0,0,0,0,0,     1,8'hA3,0,0));
        step("r34_end",  zero);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
